// File: rtl/rng_byte_packer.sv
// Packs a random bit stream (optionally von Neumann debiased) MSB-first into bytes
// and buffers them in a small FIFO; any NIST health error blocks output until reset.
module rng_byte_packer #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rnd_in,
  input  logic [3:0]    err_in,
  input  logic          vn_en,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic          health_fail
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a byte moves on every rising edge where out_valid && out_ready;
  // out_data is held stable while out_valid=1 and out_ready=0.

  logic [6:0]    shreg_q, shreg_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          first_q, first_d;
  logic          vn_prev_q, vn_prev_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          fail_q, fail_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic          mode_chg;
  logic          bit_ok;
  logic          bit_val;
  logic          byte_done;
  logic [7:0]    new_byte;
  logic          pop;
  logic          push;
  logic          full;

  assign out_valid   = (level_q != '0) && !fail_q;
  assign out_data    = mem_q[rd_ptr_q];
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;
  assign health_fail = fail_q;

  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    first_d    = first_q;
    vn_prev_d  = vn_en;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    fail_d     = fail_q;
    mem_d      = mem_q;
    bit_ok     = 1'b0;
    bit_val    = rnd_in;
    mode_chg   = (vn_en != vn_prev_q);

    // A mode change realigns the pair so the current bit starts a fresh pair.
    if (vn_en) begin
      if (mode_chg || !phase_q) begin
        first_d = rnd_in;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (rnd_in != first_q) begin
          bit_ok  = 1'b1;
          bit_val = first_q;
        end
      end
    end else begin
      phase_d = 1'b0;
      bit_ok  = 1'b1;
    end

    byte_done = bit_ok && (cnt_q == 3'd7);
    new_byte  = {shreg_q, bit_val};
    if (bit_ok) begin
      shreg_d = {shreg_q[5:0], bit_val};
      cnt_d   = cnt_q + 3'd1;
    end

    pop  = out_valid && out_ready;
    full = (level_q == LW'(DEPTH));
    push = byte_done && (!full || pop);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = new_byte;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    if (byte_done && !push) begin
      overflow_d = 1'b1;
    end

    // A health error outranks push, pop and overflow, and latches until reset.
    if (fail_q || (err_in != 4'd0)) begin
      fail_d     = 1'b1;
      shreg_d    = '0;
      cnt_d      = '0;
      phase_d    = 1'b0;
      first_d    = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = overflow_q;
      mem_d      = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      first_q    <= 1'b0;
      vn_prev_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      fail_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      first_q    <= first_d;
      vn_prev_q  <= vn_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      fail_q     <= fail_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: doc/rng_byte_packer.md
# rng_byte_packer

Downstream consumer of the ALFSR's digitised random bit stream, alongside the NIST SP 800-22 health tests. Optionally applies von Neumann debiasing, packs accepted bits MSB-first into bytes, and buffers them in a small FIFO behind a valid/ready output. Any assertion of the NIST error flags permanently blocks output until reset, so no bytes from a failed source ever leave the chip.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥2.
- `LW`, default 3: width of `fifo_level`. Equals clog2(`DEPTH`)+1.

Ports:
- `clk`  in  1  single clock; everything updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rnd_in`  in  1  random bit, sampled every cycle (the registered RND_in stream).
- `err_in`  in  4  NIST test error flags error1..error4 (bit0 = error1).
- `vn_en`  in  1  1 = von Neumann debias, 0 = raw (every bit accepted).
- `out_data`  out  8  FIFO head byte; valid only while `out_valid`=1.
- `out_valid`  out  1  FIFO non-empty and not failed.
- `out_ready`  in  1  consumer accepts a byte when `out_valid`&`out_ready`.
- `fifo_level`  out  LW  bytes currently stored, 0..DEPTH.
- `overflow`  out  1  sticky: a completed byte was dropped because the FIFO was full.
- `health_fail`  out  1  sticky: `err_in` was nonzero at some sampled edge.

## Operation
- **Reset.** While `rst`=1, at each edge clear the shift register, bit count, pair phase, FIFO pointers, `overflow` and `health_fail`. All outputs then read 0.
- **Raw mode** (`vn_en`=0): every cycle `rnd_in` is an accepted bit.
- **VN mode** (`vn_en`=1):
  - A pair-phase flag toggles every cycle.
  - Phase 0: store `rnd_in` as the first bit.
  - Phase 1: if `rnd_in` ≠ stored bit, accept the stored bit (pair 10 → 1, pair 01 → 0); if equal, discard both.
- **Mode change.** Any cycle where `vn_en` differs from its registered value from the previous edge resets pair phase to 0. That cycle's bit is treated as a phase-0 first bit in VN mode, or accepted in raw mode.
- **Packing.**
  - Each accepted bit: shreg ← {shreg[6:0], bit}; count increments 0..7.
  - On the 8th bit, {shreg[6:0], bit} is pushed to the FIFO in the same edge, and count wraps to 0.
- **FIFO push/pop.**
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, `overflow` sets, and FIFO contents are unchanged.
  - Pop occurs when `out_valid`&`out_ready`.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
  - Pointers wrap modulo `DEPTH`.
- **Health.**
  - If `err_in`≠0 at an edge, `health_fail` sets at that edge.
  - That same edge empties the FIFO (level 0), clears the packer, and discards any byte completing on it.
  - While `health_fail`=1: no pushes, `out_valid`=0, and the packer stays cleared. Only `rst` clears it.
- **`out_data`** is driven directly from FIFO storage at the read pointer. It holds stable while `out_valid`=1 and `out_ready`=0.

## Timing
- **Raw mode latency:** the bit sampled at edge k is the LSB of a byte pushed at edge k if it completes the byte. `out_valid` rises right after that edge, so the first byte is visible after 8 edges.
- **VN mode:** one accepted bit per 2 cycles at most. Minimum 16 cycles per byte; throughput is data dependent.
- **`fifo_level`, `overflow`, `health_fail`, `out_valid`:** all registered; each reflects the state after the most recent edge.
- **Pop:** the byte is consumed at the edge where `out_valid`&`out_ready`=1. The next head appears right after that edge.
- **`err_in` priority:** it takes priority over push, pop and overflow in the same edge.
- **`rst` priority:** it takes priority over everything, including `err_in`.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with random `rnd_in`/`err_in` → `out_valid`, `fifo_level`, `overflow`, `health_fail` all 0.
- **Raw pack:** `vn_en`=0, `out_ready`=0, `rnd_in` = 1,0,1,1,0,0,1,0 on consecutive edges.
  - After the 8th edge: `out_valid`=1, `out_data`=8'hB2, `fifo_level`=1.
  - Then `out_ready`=1 for one cycle → `fifo_level`=0, `out_valid`=0.
- **VN:** `vn_en`=1, pairs 10,01,00,11,10,10,01,01,10,01 → accepted bits 1,0,1,1,0,0,1,0.
  - Byte 8'hB2 is pushed on the 20th edge.
  - Mid-stream `vn_en` toggle: the phase realigns from the toggle cycle.
- **Overflow:** `vn_en`=0, `out_ready`=0, `DEPTH`=4, 40 cycles of the pattern 8'hA5 repeated.
  - `fifo_level`=4, `overflow`=1 after edge 40.
  - Draining yields exactly four 8'hA5.
  - Then push while full with `out_ready`=1 on the same cycle → no overflow, level stays 4.
- **Health fail:** FIFO holding 2 bytes, `err_in`=4'b0100 for one cycle.
  - Next cycle: `health_fail`=1, `out_valid`=0, `fifo_level`=0.
  - Stays so for 50 cycles of raw input with `err_in`=0.
  - `rst` pulse clears it and packing resumes.
- **Priority:** `err_in`≠0 on the edge that completes a byte while `out_ready`=1 → byte discarded, level 0, `overflow` unchanged.
